// File: rtl/ws2812_rx_if.sv
// Signal bundle between the WS2812 pulse-width decoder and its consumer.
// The decoder uses the slave view; the stream source and checker use master.
interface ws2812_rx_if #(
  parameter int IDX_W = 8
);
  logic             din;
  logic [23:0]      pixel_data;
  logic             pixel_valid;
  logic [IDX_W-1:0] pixel_index;
  logic             frame_done;
  logic [IDX_W-1:0] frame_pixels;
  logic             bit_error;
  logic [7:0]       err_count;
  logic             busy;

  modport slave (
    input  din,
    output pixel_data, pixel_valid, pixel_index, frame_done,
    output frame_pixels, bit_error, err_count, busy
  );

  modport master (
    output din,
    input  pixel_data, pixel_valid, pixel_index, frame_done,
    input  frame_pixels, bit_error, err_count, busy
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 NRZ decoder: classifies high-pulse widths into bits, assembles
// 24-bit GRB pixels MSB first and flags pixel/frame boundaries and errors.
module ws2812_rx #(
  parameter int THRESH_HI = 60,
  parameter int MIN_HIGH  = 20,
  parameter int MAX_HIGH  = 110,
  parameter int RESET_LOW = 5000,
  parameter int IDX_W     = 8
) (
  input logic        clock,
  input logic        reset,
  ws2812_rx_if.slave bus
);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_LOW + 1);
  localparam logic [HW-1:0] THR_H = HW'(THRESH_HI);
  localparam logic [HW-1:0] MIN_H = HW'(MIN_HIGH);
  localparam logic [HW-1:0] MAX_H = HW'(MAX_HIGH);
  localparam logic [LW-1:0] RL_M1 = LW'(RESET_LOW - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, ds_q, ds_prev_q, armed_q;
  logic [1:0]       settle_q;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [LW-1:0]    lcnt_q, lcnt_d;
  logic [4:0]       bitcnt_q, bitcnt_d;
  logic [IDX_W-1:0] pixcnt_q, pixcnt_d;
  logic [23:0]      shift_q, shift_d;
  logic             pix_valid_d, frame_done_d, bit_error_d;
  logic [23:0]      pix_data_q;
  logic             pix_valid_q, frame_done_q, bit_error_q, busy_q;
  logic [IDX_W-1:0] pix_index_q, frame_pixels_q;
  logic [7:0]       err_count_q;
  logic             rise, fall;

  // armed_q blocks a line that was already high when reset released
  assign rise = armed_q & ds_q & ~ds_prev_q;
  assign fall = ~ds_q & ds_prev_q;

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    bitcnt_d     = bitcnt_q;
    pixcnt_d     = pixcnt_q;
    shift_d      = shift_q;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    bit_error_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = HIGH;
          hcnt_d   = HW'(1);
          bitcnt_d = 5'd0;
          pixcnt_d = '0;
        end
      end
      HIGH: begin
        if (fall) begin
          if (hcnt_q < MIN_H) begin
            bit_error_d = 1'b1;
            bitcnt_d    = 5'd0;
          end else begin
            shift_d  = {shift_q[22:0], (hcnt_q >= THR_H)};
            bitcnt_d = bitcnt_q + 5'd1;
          end
          lcnt_d  = LW'(1);
          state_d = LOW;
        end else if (hcnt_q == MAX_H) begin
          bit_error_d = 1'b1;
          bitcnt_d    = 5'd0;
          state_d     = STUCK;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      LOW: begin
        if (bitcnt_q == 5'd24) begin
          pix_valid_d = 1'b1;
          bitcnt_d    = 5'd0;
          if (!(&pixcnt_q)) pixcnt_d = pixcnt_q + IDX_W'(1);
        end
        if (rise) begin
          state_d = HIGH;
          hcnt_d  = HW'(1);
        end else if (lcnt_q == RL_M1) begin
          frame_done_d = 1'b1;
          bit_error_d  = (bitcnt_q != 5'd0);
          bitcnt_d     = 5'd0;
          state_d      = IDLE;
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end
      STUCK: begin
        if (!ds_q) begin
          state_d = LOW;
          lcnt_d  = LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      sync1_q        <= 1'b0;
      ds_q           <= 1'b0;
      ds_prev_q      <= 1'b0;
      settle_q       <= 2'b00;
      armed_q        <= 1'b0;
      hcnt_q         <= '0;
      lcnt_q         <= '0;
      bitcnt_q       <= 5'd0;
      pixcnt_q       <= '0;
      shift_q        <= 24'd0;
      pix_data_q     <= 24'd0;
      pix_valid_q    <= 1'b0;
      pix_index_q    <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      bit_error_q    <= 1'b0;
      err_count_q    <= 8'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= bus.din;
      ds_q         <= sync1_q;
      ds_prev_q    <= ds_q;
      settle_q     <= {settle_q[0], 1'b1};
      // settle_q[1] marks the first cycle ds_q carries a real pin sample
      armed_q      <= armed_q | (settle_q[1] & ~ds_q);
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      bitcnt_q     <= bitcnt_d;
      pixcnt_q     <= pixcnt_d;
      shift_q      <= shift_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      bit_error_q  <= bit_error_d;
      busy_q       <= (state_q != IDLE);
      if (pix_valid_d) begin
        pix_data_q  <= shift_q;
        pix_index_q <= pixcnt_q;
      end
      if (frame_done_d) frame_pixels_q <= pixcnt_q;
      if (bit_error_d && !(&err_count_q)) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.pixel_data   = pix_data_q;
  assign bus.pixel_valid  = pix_valid_q;
  assign bus.pixel_index  = pix_index_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.frame_pixels = frame_pixels_q;
  assign bus.bit_error    = bit_error_q;
  assign bus.err_count    = err_count_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: drives WS2812 waveforms on din and checks the
// logged pixel, frame and error strobes against hand-computed values.
module tb_ws2812_rx;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ws2812_rx_if #(.IDX_W(8)) bus ();

  ws2812_rx dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] pix_data_log[$];
  logic [31:0] pix_idx_log[$];
  logic [31:0] fd_pix_log[$];
  logic [31:0] fd_err_log[$];
  logic [31:0] fd_busy_log[$];
  logic [31:0] busy_after_log[$];
  logic [31:0] err_log[$];
  logic        fd_prev;

  initial fd_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.pixel_valid) begin
      pix_data_log.push_back({8'd0, bus.pixel_data});
      pix_idx_log.push_back({24'd0, bus.pixel_index});
    end
    if (bus.frame_done) begin
      fd_pix_log.push_back({24'd0, bus.frame_pixels});
      fd_err_log.push_back({31'd0, bus.bit_error});
      fd_busy_log.push_back({31'd0, bus.busy});
    end
    if (fd_prev) busy_after_log.push_back({31'd0, bus.busy});
    if (bus.bit_error) err_log.push_back({24'd0, bus.err_count});
    fd_prev <= bus.frame_done;
  end

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEADBEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input int hi, input int lo);
    bus.din = 1'b1;
    repeat (hi) @(negedge clk);
    bus.din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_data(input logic [23:0] v, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) begin
      if (v[i]) send_bit(80, 45);
      else      send_bit(40, 85);
    end
  endtask

  task automatic gap(input int n);
    bus.din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, {8'd0, bus.pixel_data}, 32'd0);
    check({tag, "_flags"}, {4'd0, bus.pixel_valid, bus.frame_done, bus.bit_error, bus.busy,
                            bus.pixel_index, bus.frame_pixels, bus.err_count}, 32'd0);
  endtask

  int pb, fb, eb, ab;

  initial begin
    rst     = 1'b1;
    bus.din = 1'b0;
    repeat (5) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    gap(10);

    // Clean pixel 0x00FF00
    pb = pix_data_log.size(); fb = fd_pix_log.size(); eb = err_log.size(); ab = busy_after_log.size();
    send_data(24'h00FF00, 24);
    gap(6000);
    check("t1_npix", pix_data_log.size() - pb, 1);
    check("t1_data", qat(pix_data_log, pb), 32'h00FF00);
    check("t1_idx", qat(pix_idx_log, pb), 0);
    check("t1_nframe", fd_pix_log.size() - fb, 1);
    check("t1_fpix", qat(fd_pix_log, fb), 1);
    check("t1_nerr", err_log.size() - eb, 0);
    check("t1_busy_after", qat(busy_after_log, ab), 0);

    // Three-pixel frame
    pb = pix_data_log.size(); fb = fd_pix_log.size(); eb = err_log.size(); ab = busy_after_log.size();
    send_data(24'h123456, 24);
    send_data(24'hABCDEF, 24);
    send_data(24'h000001, 24);
    gap(6000);
    check("t2_npix", pix_data_log.size() - pb, 3);
    check("t2_data0", qat(pix_data_log, pb), 32'h123456);
    check("t2_idx0", qat(pix_idx_log, pb), 0);
    check("t2_data1", qat(pix_data_log, pb + 1), 32'hABCDEF);
    check("t2_idx1", qat(pix_idx_log, pb + 1), 1);
    check("t2_data2", qat(pix_data_log, pb + 2), 32'h000001);
    check("t2_idx2", qat(pix_idx_log, pb + 2), 2);
    check("t2_fpix", qat(fd_pix_log, fb), 3);
    check("t2_busy_at_fd", qat(fd_busy_log, fb), 1);
    check("t2_busy_after", qat(busy_after_log, ab), 0);
    check("t2_nerr", err_log.size() - eb, 0);

    // Threshold boundary: 59,60,20,110 -> 0,1,0,1; remainder 0xA5A5A
    pb = pix_data_log.size(); fb = fd_pix_log.size(); eb = err_log.size();
    send_bit(59, 70);
    send_bit(60, 70);
    send_bit(20, 70);
    send_bit(110, 70);
    send_data(24'hA5A5A0, 20);
    gap(6000);
    check("t3_npix", pix_data_log.size() - pb, 1);
    check("t3_data", qat(pix_data_log, pb), 32'h5A5A5A);
    check("t3_idx", qat(pix_idx_log, pb), 0);
    check("t3_fpix", qat(fd_pix_log, fb), 1);
    check("t3_nerr", err_log.size() - eb, 0);

    // Glitch of 19 cycles
    pb = pix_data_log.size(); fb = fd_pix_log.size(); eb = err_log.size();
    send_bit(19, 100);
    check("t4_glitch_nerr", err_log.size() - eb, 1);
    check("t4_glitch_cnt", qat(err_log, eb), 1);
    gap(6000);
    check("t4_glitch_fpix", qat(fd_pix_log, fb), 0);
    check("t4_glitch_fderr", qat(fd_err_log, fb), 0);

    // Stuck-high 200-cycle pulse, then a good pixel
    eb = err_log.size(); fb = fd_pix_log.size();
    bus.din = 1'b1;
    repeat (150) @(negedge clk);
    check("t4_stuck_nerr", err_log.size() - eb, 1);
    check("t4_stuck_cnt", qat(err_log, eb), 2);
    check("t4_stuck_busy", {31'd0, bus.busy}, 1);
    repeat (50) @(negedge clk);
    gap(100);
    check("t4_stuck_nerr_after", err_log.size() - eb, 1);
    send_data(24'hC3C3C3, 24);
    gap(6000);
    check("t4_npix", pix_data_log.size() - pb, 1);
    check("t4_data", qat(pix_data_log, pb), 32'hC3C3C3);
    check("t4_idx", qat(pix_idx_log, pb), 0);
    check("t4_fpix", qat(fd_pix_log, fb), 1);

    // Partial pixel: 10 bits then latch gap
    pb = pix_data_log.size(); fb = fd_pix_log.size(); eb = err_log.size();
    send_data(24'hB6D000, 10);
    gap(6000);
    check("t5_npix", pix_data_log.size() - pb, 0);
    check("t5_fpix", qat(fd_pix_log, fb), 0);
    check("t5_fderr", qat(fd_err_log, fb), 1);
    check("t5_errcnt", qat(err_log, eb), 3);

    // Reset after 12 bits, then a full pixel
    send_data(24'hFFF000, 12);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("t6_reset");
    pb = pix_data_log.size(); fb = fd_pix_log.size(); eb = err_log.size();
    rst = 1'b0;
    gap(10);
    send_data(24'h9E3779, 24);
    gap(6000);
    check("t6_npix", pix_data_log.size() - pb, 1);
    check("t6_data", qat(pix_data_log, pb), 32'h9E3779);
    check("t6_idx", qat(pix_idx_log, pb), 0);
    check("t6_nframe", fd_pix_log.size() - fb, 1);
    check("t6_fpix", qat(fd_pix_log, fb), 1);
    check("t6_nerr", err_log.size() - eb, 0);
    check("t6_errcnt", {24'd0, bus.err_count}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
